// File: rtl/rom_burst_reader.sv
// Synchronous ROM (mem[i] = i*STEP mod 2**DATA_W) with single and
// auto-incrementing burst reads, a req/busy handshake and valid/last tagging.
module rom_burst_reader #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 2,
  parameter int STEP    = 5,
  parameter int REG_OUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_req_drop,
  output logic              o_valid,
  output logic              o_last,
  output logic [DATA_W-1:0] o_data_out
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   LEN_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

  // Truncating both factors first gives the same result as (i*STEP) mod 2**DATA_W.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] idx);
    return DATA_W'(idx) * DATA_W'(STEP);
  endfunction

  state_t            r_state;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W-1:0] r_cur;
  logic              r_req_drop;

  logic              w_accept;
  logic              w_issue;
  logic              w_issue_last;
  logic [ADDR_W-1:0] w_issue_addr;

  logic              r_s1_valid;
  logic              r_s1_last;
  logic [DATA_W-1:0] r_s1_data;

  // Issue decode: which beat (if any) is launched into the pipeline this edge.
  always_comb begin
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = ADDR_W'(0);
    case (r_state)
      ST_IDLE: begin
        if (i_req && i_en && (i_len != LEN_ZERO)) begin
          w_accept     = 1'b1;
          w_issue      = 1'b1;
          w_issue_last = (i_len == LEN_ONE);
          w_issue_addr = i_addr;
        end else begin
          w_accept = 1'b0;
        end
      end
      ST_BURST: begin
        if (i_en) begin
          w_issue      = 1'b1;
          w_issue_last = (r_rem == LEN_ONE);
          w_issue_addr = r_cur;
        end else begin
          w_issue = 1'b0;
        end
      end
      default: begin
        w_issue = 1'b0;
      end
    endcase
  end

  // Burst control FSM: remaining-beat count, next address and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rem      <= LEN_ZERO;
      r_cur      <= ADDR_W'(0);
      r_req_drop <= 1'b0;
    end else begin
      r_req_drop <= i_req && (r_state == ST_BURST);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rem   <= i_len - LEN_ONE;
            r_cur   <= i_addr + ADDR_ONE;
            r_state <= (i_len == LEN_ONE) ? ST_IDLE : ST_BURST;
          end
        end
        ST_BURST: begin
          // en=0 stalls: rem and cur simply hold.
          if (i_en) begin
            r_rem <= r_rem - LEN_ONE;
            r_cur <= r_cur + ADDR_ONE;
            if (r_rem == LEN_ONE) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rem   <= LEN_ZERO;
        end
      endcase
    end
  end

  // ROM read stage; data is forced to zero whenever no beat is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_data  <= DATA_ZERO;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_last  <= w_issue && w_issue_last;
      r_s1_data  <= w_issue ? rom_word(w_issue_addr) : DATA_ZERO;
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic              r_s2_valid;
      logic              r_s2_last;
      logic [DATA_W-1:0] r_s2_data;

      // Optional output register: one extra cycle of latency.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_last  <= 1'b0;
          r_s2_data  <= DATA_ZERO;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_last  <= r_s1_last;
          r_s2_data  <= r_s1_data;
        end
      end

      assign o_valid    = r_s2_valid;
      assign o_last     = r_s2_last;
      assign o_data_out = r_s2_data;
    end else begin : g_no_reg_out
      assign o_valid    = r_s1_valid;
      assign o_last     = r_s1_last;
      assign o_data_out = r_s1_data;
    end
  endgenerate

  assign o_busy     = (r_state == ST_BURST);
  assign o_req_drop = r_req_drop;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: a vector table for the default build
// plus hand sequences for async reset and the REG_OUT=1 variant.
module tb_rom_burst_reader;

  logic       clk;
  logic       rst_n;
  logic       en, req;
  logic [1:0] addr;
  logic [2:0] len;
  logic       busy, req_drop, valid, last;
  logic [3:0] data_out;

  logic       rst2_n;
  logic       en2, req2;
  logic [1:0] addr2;
  logic [2:0] len2;
  logic       busy2, req_drop2, valid2, last2;
  logic [3:0] data_out2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       req;
    logic       en;
    logic [1:0] addr;
    logic [2:0] len;
    logic       v;
    logic       l;
    logic [3:0] d;
    logic       busy;
    logic       drop;
  } vec_t;

  vec_t vecs[$];

  rom_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_req(req), .i_addr(addr), .i_len(len),
    .o_busy(busy), .o_req_drop(req_drop), .o_valid(valid), .o_last(last),
    .o_data_out(data_out)
  );

  rom_burst_reader #(.REG_OUT(1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i_en(en2), .i_req(req2), .i_addr(addr2), .i_len(len2),
    .o_busy(busy2), .o_req_drop(req_drop2), .o_valid(valid2), .o_last(last2),
    .o_data_out(data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {busy, drop, valid, last, data}
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {busy,drop,valid,last,data}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic rq, input logic e, input logic [1:0] a, input logic [2:0] ln,
                     input logic v, input logic l, input logic [3:0] d,
                     input logic b, input logic dr);
    vec_t t;
    t.req = rq; t.en = e; t.addr = a; t.len = ln;
    t.v = v; t.l = l; t.d = d; t.busy = b; t.drop = dr;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rq, input logic e, input logic [1:0] a, input logic [2:0] ln);
    req = rq; en = e; addr = a; len = ln;
  endtask

  task automatic drive2(input logic rq, input logic e, input logic [1:0] a, input logic [2:0] ln);
    req2 = rq; en2 = e; addr2 = a; len2 = ln;
  endtask

  initial begin
    // single read
    add(1'b1, 1'b1, 2'd2, 3'd1,  1'b1, 1'b1, 4'd10, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
    // wrapping burst 3 -> 0 -> 1
    add(1'b1, 1'b1, 2'd3, 3'd3,  1'b1, 1'b0, 4'd15, 1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b1, 4'd5,  1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
    // two-cycle stall after beat 1
    add(1'b1, 1'b1, 2'd0, 3'd4,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd5,  1'b1, 1'b0);
    add(1'b0, 1'b0, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0);
    add(1'b0, 1'b0, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd10, 1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
    // request while busy is dropped
    add(1'b1, 1'b1, 2'd1, 3'd4,  1'b1, 1'b0, 4'd5,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd10, 1'b1, 1'b0);
    add(1'b1, 1'b1, 2'd0, 3'd1,  1'b1, 1'b0, 4'd15, 1'b1, 1'b1);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b1, 4'd0,  1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
    // len==0 and en==0 requests are ignored
    add(1'b1, 1'b1, 2'd2, 3'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
    add(1'b1, 1'b0, 2'd2, 3'd2,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
    // back-to-back requests, gap-free output
    add(1'b1, 1'b1, 2'd3, 3'd1,  1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
    add(1'b1, 1'b1, 2'd0, 3'd2,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b1, 4'd5,  1'b0, 1'b0);
    // len > DEPTH re-reads wrapped entries
    add(1'b1, 1'b1, 2'd2, 3'd5,  1'b1, 1'b0, 4'd10, 1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd15, 1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b0, 4'd5,  1'b1, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b1, 1'b1, 4'd10, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd0, 3'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0);

    rst_n = 1'b0; rst2_n = 1'b0;
    drive(1'b0, 1'b1, 2'd0, 3'd0);
    drive2(1'b0, 1'b1, 2'd0, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {busy, req_drop, valid, last, data_out}, 8'h00);
    check("reset_state2", {busy2, req_drop2, valid2, last2, data_out2}, 8'h00);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].en, vecs[i].addr, vecs[i].len);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {busy, req_drop, valid, last, data_out},
            {vecs[i].busy, vecs[i].drop, vecs[i].v, vecs[i].l, vecs[i].d});
    end

    // Async reset mid-burst: outputs clear immediately, burst is discarded
    drive(1'b1, 1'b1, 2'd0, 3'd4);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'd0, 3'd0);
    @(posedge clk); #1;
    check("pre_reset_beat1", {busy, req_drop, valid, last, data_out}, 8'b1010_0101);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy, req_drop, valid, last, data_out}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset%0d", k), {busy, req_drop, valid, last, data_out}, 8'h00);
    end

    // REG_OUT=1: latency of two cycles
    drive2(1'b1, 1'b1, 2'd1, 3'd2);
    @(posedge clk); #1;
    drive2(1'b0, 1'b1, 2'd0, 3'd0);
    check("r2_accept", {busy2, req_drop2, valid2, last2, data_out2}, 8'b1000_0000);
    @(posedge clk); #1;
    check("r2_beat0", {busy2, req_drop2, valid2, last2, data_out2}, 8'b0010_0101);
    @(posedge clk); #1;
    check("r2_beat1", {busy2, req_drop2, valid2, last2, data_out2}, 8'b0011_1010);
    @(posedge clk); #1;
    check("r2_idle", {busy2, req_drop2, valid2, last2, data_out2}, 8'h00);

    // REG_OUT=1 reset mid-burst: nothing further emerges from the pipeline
    drive2(1'b1, 1'b1, 2'd1, 3'd4);
    @(posedge clk); #1;
    drive2(1'b0, 1'b1, 2'd0, 3'd0);
    @(posedge clk); #1;
    check("r2_b_beat0", {busy2, req_drop2, valid2, last2, data_out2}, 8'b1010_0101);
    #2 rst2_n = 1'b0;
    #1 check("r2_async_reset", {busy2, req_drop2, valid2, last2, data_out2}, 8'h00);
    @(negedge clk); rst2_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("r2_post_reset%0d", k), {busy2, req_drop2, valid2, last2, data_out2}, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
